// File: rtl/bbox_scheduler_if.sv
// Edge-search engine bus: scheduler launches a windowed directional search,
// engine reports a level done plus the first set-pixel coordinate it hit.
interface bbox_scheduler_if;
    logic       eng_start;
    logic [9:0] eng_x0;
    logic [9:0] eng_y0;
    logic [9:0] eng_x1;
    logic [9:0] eng_y1;
    logic [1:0] eng_dir;
    logic       eng_done;
    logic       eng_found;
    logic [9:0] eng_fx;
    logic [9:0] eng_fy;

    modport master (
        output eng_start, eng_x0, eng_y0, eng_x1, eng_y1, eng_dir,
        input  eng_done, eng_found, eng_fx, eng_fy
    );

    modport slave (
        input  eng_start, eng_x0, eng_y0, eng_x1, eng_y1, eng_dir,
        output eng_done, eng_found, eng_fx, eng_fy
    );
endinterface

// File: rtl/bbox_scheduler.sv
// Bounding-box scheduler: runs four directional edge-search passes
// (top, bottom, left, right) over a region and reports the enclosing box.
module bbox_scheduler #(
    parameter int TIMEOUT = 400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] rx0,
    input  logic [9:0] ry0,
    input  logic [9:0] rx1,
    input  logic [9:0] ry1,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic       err,
    output logic [9:0] box_top,
    output logic [9:0] box_bottom,
    output logic [9:0] box_left,
    output logic [9:0] box_right,
    bbox_scheduler_if.master eng
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_STORE  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [1:0] P_TOP    = 2'd0;
    localparam logic [1:0] P_BOTTOM = 2'd1;
    localparam logic [1:0] P_LEFT   = 2'd2;
    localparam logic [1:0] P_RIGHT  = 2'd3;

    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_DOWN  = 2'b01;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_RIGHT = 2'b11;

    localparam logic [18:0] TMO = 19'(TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [1:0]  pass_q, pass_d;
    logic [18:0] cnt_q, cnt_d;
    logic [9:0]  rx0_q, rx0_d, ry0_q, ry0_d, rx1_q, rx1_d, ry1_q, ry1_d;
    // working coordinates; kept apart from box_* so the reported box stays
    // stable while the next request is running
    logic [9:0]  top_q, top_d, bot_q, bot_d, left_q, left_d, right_q, right_d;
    logic        valid_q, valid_d, err_q, err_d;
    logic [9:0]  btop_q, btop_d, bbot_q, bbot_d, bleft_q, bleft_d, bright_q, bright_d;
    logic [9:0]  wx0_q, wx0_d, wy0_q, wy0_d, wx1_q, wx1_d, wy1_q, wy1_d;
    logic [1:0]  dir_q, dir_d;

    logic fin, fin_valid, fin_err, load_win;

    // next-state, pass sequencing, result capture and window selection
    always_comb begin
        state_d = state_q;  pass_d = pass_q;  cnt_d = cnt_q;
        rx0_d = rx0_q;  ry0_d = ry0_q;  rx1_d = rx1_q;  ry1_d = ry1_q;
        top_d = top_q;  bot_d = bot_q;  left_d = left_q;  right_d = right_q;
        valid_d = valid_q;  err_d = err_q;
        btop_d = btop_q;  bbot_d = bbot_q;  bleft_d = bleft_q;  bright_d = bright_q;
        wx0_d = wx0_q;  wy0_d = wy0_q;  wx1_d = wx1_q;  wy1_d = wy1_q;  dir_d = dir_q;
        fin = 1'b0;  fin_valid = 1'b0;  fin_err = 1'b0;  load_win = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (rx0 <= rx1 && ry0 <= ry1) begin
                        rx0_d = rx0;  ry0_d = ry0;  rx1_d = rx1;  ry1_d = ry1;
                        pass_d   = P_TOP;
                        load_win = 1'b1;
                        state_d  = S_LAUNCH;
                    end else begin
                        fin = 1'b1;  fin_err = 1'b1;
                        state_d = S_FINISH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_ARM;
            end
            // engine may still show done from the previous pass here
            S_ARM: state_d = S_WAIT;
            S_WAIT: begin
                cnt_d = cnt_q + 19'd1;
                if (eng.eng_done) begin
                    state_d = S_STORE;
                end else if (cnt_d >= TMO) begin
                    fin = 1'b1;  fin_err = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_STORE: begin
                if (!eng.eng_found) begin
                    // nothing on the top pass is an empty region; a miss after
                    // a hit means the engine contradicted itself
                    fin = 1'b1;  fin_err = (pass_q != P_TOP);
                    state_d = S_FINISH;
                end else begin
                    case (pass_q)
                        P_TOP:    top_d   = eng.eng_fy;
                        P_BOTTOM: bot_d   = eng.eng_fy;
                        P_LEFT:   left_d  = eng.eng_fx;
                        default:  right_d = eng.eng_fx;
                    endcase
                    if (pass_q == P_RIGHT) begin
                        fin = 1'b1;  fin_valid = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        pass_d   = pass_q + 2'd1;
                        load_win = 1'b1;
                        state_d  = S_LAUNCH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (load_win) begin
            case (pass_d)
                P_TOP:    begin wx0_d = rx0_d; wy0_d = ry0_d; wx1_d = rx1_d; wy1_d = ry1_d; dir_d = D_RIGHT; end
                P_BOTTOM: begin wx0_d = rx1_d; wy0_d = ry1_d; wx1_d = rx0_d; wy1_d = top_d; dir_d = D_LEFT;  end
                P_LEFT:   begin wx0_d = rx0_d; wy0_d = top_d; wx1_d = rx1_d; wy1_d = bot_d; dir_d = D_DOWN;  end
                default:  begin wx0_d = rx1_d; wy0_d = bot_d; wx1_d = rx0_d; wy1_d = top_d; dir_d = D_UP;    end
            endcase
        end

        if (fin) begin
            valid_d  = fin_valid;
            err_d    = fin_err;
            btop_d   = fin_valid ? top_d   : 10'd0;
            bbot_d   = fin_valid ? bot_d   : 10'd0;
            bleft_d  = fin_valid ? left_d  : 10'd0;
            bright_d = fin_valid ? right_d : 10'd0;
        end
    end

    // state registers with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;  pass_q <= P_TOP;  cnt_q <= '0;
            rx0_q <= '0;  ry0_q <= '0;  rx1_q <= '0;  ry1_q <= '0;
            top_q <= '0;  bot_q <= '0;  left_q <= '0;  right_q <= '0;
            valid_q <= 1'b0;  err_q <= 1'b0;
            btop_q <= '0;  bbot_q <= '0;  bleft_q <= '0;  bright_q <= '0;
            wx0_q <= '0;  wy0_q <= '0;  wx1_q <= '0;  wy1_q <= '0;  dir_q <= D_UP;
        end else begin
            state_q <= state_d;  pass_q <= pass_d;  cnt_q <= cnt_d;
            rx0_q <= rx0_d;  ry0_q <= ry0_d;  rx1_q <= rx1_d;  ry1_q <= ry1_d;
            top_q <= top_d;  bot_q <= bot_d;  left_q <= left_d;  right_q <= right_d;
            valid_q <= valid_d;  err_q <= err_d;
            btop_q <= btop_d;  bbot_q <= bbot_d;  bleft_q <= bleft_d;  bright_q <= bright_d;
            wx0_q <= wx0_d;  wy0_q <= wy0_d;  wx1_q <= wx1_d;  wy1_q <= wy1_d;  dir_q <= dir_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FINISH);
    assign eng.eng_start = (state_q == S_LAUNCH);
    assign eng.eng_x0    = wx0_q;
    assign eng.eng_y0    = wy0_q;
    assign eng.eng_x1    = wx1_q;
    assign eng.eng_y1    = wy1_q;
    assign eng.eng_dir   = dir_q;
    assign valid         = valid_q;
    assign err           = err_q;
    assign box_top       = btop_q;
    assign box_bottom    = bbot_q;
    assign box_left      = bleft_q;
    assign box_right     = bright_q;
endmodule

// File: tb/tb_bbox_scheduler.sv
// Bench for bbox_scheduler: rectangular-blob engine model plus a box-level
// reference computed from region/blob intersection.
module tb_bbox_scheduler;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [9:0] rx0, ry0, rx1, ry1;
    logic       busy, done, valid, err;
    logic [9:0] box_top, box_bottom, box_left, box_right;

    bbox_scheduler_if eng();

    bbox_scheduler #(.TIMEOUT(50)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx0(rx0), .ry0(ry0), .rx1(rx1), .ry1(ry1),
        .busy(busy), .done(done), .valid(valid), .err(err),
        .box_top(box_top), .box_bottom(box_bottom),
        .box_left(box_left), .box_right(box_right),
        .eng(eng)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction
    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction

    // ---------------- engine model ----------------
    int bx0, by0, bx1, by1;                   // blob rectangle (inclusive)
    int e_lat = 1, e_stale = 0, e_hang = 0, e_bad = 0;
    logic       e_done = 1'b0, e_found = 1'b0;
    logic [9:0] e_fx = '0, e_fy = '0;
    logic       e_act = 1'b0;
    int         e_k = 0;
    logic [9:0] ew_x0 = '0, ew_y0 = '0, ew_x1 = '0, ew_y1 = '0;
    logic [1:0] ew_dir = '0;
    int n = 0;
    int lg_x0[1024], lg_y0[1024], lg_x1[1024], lg_y1[1024], lg_dir[1024], lg_cyc[1024];

    assign eng.eng_done  = e_done;
    assign eng.eng_found = e_found;
    assign eng.eng_fx    = e_fx;
    assign eng.eng_fy    = e_fy;

    // searches the window rectangle for the blob; returns {found, fx, fy}
    function automatic logic [20:0] eval(input logic [1:0] d, input int x0, input int y0,
                                         input int x1, input int y1);
        int ix0, ix1, iy0, iy1;
        logic f;
        ix0 = imax(imin(x0, x1), bx0);  ix1 = imin(imax(x0, x1), bx1);
        iy0 = imax(imin(y0, y1), by0);  iy1 = imin(imax(y0, y1), by1);
        f = (ix0 <= ix1) && (iy0 <= iy1) && !(e_bad != 0 && d != 2'b11);
        case (d)
            2'b11:   return {f, 10'(ix0), 10'(iy0)};
            2'b10:   return {f, 10'(ix1), 10'(iy1)};
            2'b01:   return {f, 10'(ix0), 10'(iy0)};
            default: return {f, 10'(ix1), 10'(iy0)};
        endcase
    endfunction

    always @(posedge clk) begin
        if (eng.eng_start) begin
            lg_x0[n % 1024] <= eng.eng_x0;  lg_y0[n % 1024] <= eng.eng_y0;
            lg_x1[n % 1024] <= eng.eng_x1;  lg_y1[n % 1024] <= eng.eng_y1;
            lg_dir[n % 1024] <= eng.eng_dir; lg_cyc[n % 1024] <= cyc;
            n <= n + 1;
            ew_x0 <= eng.eng_x0;  ew_y0 <= eng.eng_y0;
            ew_x1 <= eng.eng_x1;  ew_y1 <= eng.eng_y1;  ew_dir <= eng.eng_dir;
            e_act <= 1'b1;  e_k <= 0;
            if (e_stale == 0) e_done <= 1'b0;
        end else if (e_act) begin
            e_k <= e_k + 1;
            if (e_hang != 0) begin
                e_done <= 1'b0;
            end else if (e_k + 1 >= e_lat) begin
                e_done <= 1'b1;  e_act <= 1'b0;
                {e_found, e_fx, e_fy} <= eval(ew_dir, ew_x0, ew_y0, ew_x1, ew_y1);
            end else begin
                e_done <= 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);   chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, valid, 0); chk({tag, "_err"}, err, 0);
        chk({tag, "_estart"}, eng.eng_start, 0); chk({tag, "_dir"}, eng.eng_dir, 0);
        chk({tag, "_win"}, {eng.eng_x0, eng.eng_y0, eng.eng_x1, eng.eng_y1}, 0);
        chk({tag, "_box"}, {box_top, box_bottom, box_left, box_right}, 0);
    endtask

    task automatic run_req(input string tag, input int ax0, input int ay0, input int ax1,
                           input int ay1, input int lat, input int stale, input int hang,
                           input int bad, input int noise);
        int et, eb, el, er, inv, empty, ev, ee, ns, lat_exp, c0, n0, got;
        inv = (ax0 > ax1) || (ay0 > ay1);
        et = imax(ay0, by0);  eb = imin(ay1, by1);
        el = imax(ax0, bx0);  er = imin(ax1, bx1);
        empty = (et > eb) || (el > er);
        ev = 0;  ee = 0;
        if (inv)           begin ee = 1; ns = 0; lat_exp = 1; end
        else if (hang)     begin ee = 1; ns = 1; lat_exp = 53; end
        else if (empty)    begin ns = 1; lat_exp = (lat + 3) + 1; end
        else if (bad)      begin ee = 1; ns = 2; lat_exp = 2 * (lat + 3) + 1; end
        else               begin ev = 1; ns = 4; lat_exp = 4 * (lat + 3) + 1; end
        e_lat = lat;  e_stale = stale;  e_hang = hang;  e_bad = bad;

        @(negedge clk);
        start = 1'b1;
        rx0 = 10'(ax0);  ry0 = 10'(ay0);  rx1 = 10'(ax1);  ry1 = 10'(ay1);
        c0 = cyc;  n0 = n;  got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin got = 1; start = 1'b0; break; end
            chk({tag, "_busy"}, busy, 1);
            start = (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise != 0) begin
                rx0 = 10'($urandom);  ry0 = 10'($urandom);
                rx1 = 10'($urandom);  ry1 = 10'($urandom);
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, got, 1);
        if (got == 0) return;
        chk({tag, "_busy_at_done"}, busy, 1);
        if (hang) chk({tag, "_tmo_lat"}, cyc - lg_cyc[n0 % 1024], 52);
        chk({tag, "_latency"}, cyc - c0, lat_exp);
        chk({tag, "_valid"}, valid, ev);
        chk({tag, "_err"}, err, ee);
        if (ev) begin
            chk({tag, "_top"}, box_top, et);     chk({tag, "_bottom"}, box_bottom, eb);
            chk({tag, "_left"}, box_left, el);   chk({tag, "_right"}, box_right, er);
        end
        chk({tag, "_nstart"}, n - n0, ns);
        for (int p = 0; p < n - n0 && p < 4; p++) begin
            int k, wx0, wy0, wx1, wy1;
            k = (n0 + p) % 1024;
            case (p)
                0:       begin wx0 = ax0; wy0 = ay0; wx1 = ax1; wy1 = ay1; end
                1:       begin wx0 = ax1; wy0 = ay1; wx1 = ax0; wy1 = et;  end
                2:       begin wx0 = ax0; wy0 = et;  wx1 = ax1; wy1 = eb;  end
                default: begin wx0 = ax1; wy0 = eb;  wx1 = ax0; wy1 = et;  end
            endcase
            chk({tag, "_dir"}, lg_dir[k], 3 - p);
            chk({tag, "_win"}, {lg_x0[k][9:0], lg_y0[k][9:0], lg_x1[k][9:0], lg_y1[k][9:0]},
                {10'(wx0), 10'(wy0), 10'(wx1), 10'(wy1)});
        end
        @(negedge clk);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_done_1cyc"}, done, 0);
        chk({tag, "_valid_held"}, valid, ev);
        chk({tag, "_err_held"}, err, ee);
    endtask

    initial begin
        reset = 1'b1;  start = 1'b0;
        rx0 = '0;  ry0 = '0;  rx1 = '0;  ry1 = '0;
        bx0 = 100;  bx1 = 120;  by0 = 50;  by1 = 60;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;
        @(negedge clk);
        chk_zero("post_rst");

        // directed cases
        run_req("full",   0, 0, 639, 479, 3, 0, 0, 0, 0);
        run_req("minlat", 0, 0, 639, 479, 1, 0, 0, 0, 0);
        run_req("empty",  0, 0, 50, 40,   2, 0, 0, 0, 0);
        run_req("inv",    10, 0, 5, 40,   2, 0, 0, 0, 0);
        run_req("tmo",    0, 0, 639, 479, 2, 0, 1, 0, 0);
        run_req("stale",  0, 0, 639, 479, 4, 1, 0, 0, 1);
        run_req("bad",    0, 0, 639, 479, 2, 0, 0, 1, 0);
        bx0 = 7;  bx1 = 7;  by0 = 7;  by1 = 7;
        run_req("pixel",  7, 7, 7, 7,     1, 1, 0, 0, 0);
        run_req("edge",   1023, 1023, 1023, 1023, 2, 0, 0, 0, 0);

        // reset during the LEFT pass
        bx0 = 100;  bx1 = 120;  by0 = 50;  by1 = 60;
        e_lat = 3;  e_stale = 0;  e_hang = 0;  e_bad = 0;
        @(negedge clk);
        start = 1'b1;  rx0 = 0;  ry0 = 0;  rx1 = 639;  ry1 = 479;
        @(negedge clk);
        start = 1'b0;
        begin
            int hit;
            hit = 0;
            for (int i = 0; i < 200; i++) begin
                if (busy && eng.eng_dir == 2'b01) begin hit = 1; break; end
                @(negedge clk);
            end
            chk("rst_mid_reach_left", hit, 1);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_zero("rst_mid");
        run_req("after_rst", 0, 0, 639, 479, 2, 1, 0, 0, 0);

        // randomized requests
        for (int t = 0; t < 40; t++) begin
            int ax0, ay0, ax1, ay1, w, h;
            ax0 = $urandom_range(0, 900);  ay0 = $urandom_range(0, 900);
            w = $urandom_range(0, 120);    h = $urandom_range(0, 120);
            ax1 = ax0 + w;  ay1 = ay0 + h;
            bx0 = imax(0, ax0 - 20 + int'($urandom_range(0, w + 40)));
            by0 = imax(0, ay0 - 20 + int'($urandom_range(0, h + 40)));
            bx1 = imin(1023, bx0 + int'($urandom_range(0, 60)));
            by1 = imin(1023, by0 + int'($urandom_range(0, 60)));
            if ($urandom_range(0, 7) == 0) begin int tmp; tmp = ax0; ax0 = ax1 + 1; ax1 = tmp; end
            run_req("rand", ax0, ay0, ax1, ay1, $urandom_range(1, 5), $urandom_range(0, 1),
                    0, ($urandom_range(0, 9) == 0) ? 1 : 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bbox_scheduler.md
BBOX_SCHEDULER -- requirements
Module: bbox_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 400000, max cycles per pass from engine_start to engine_done before abort.
REQ-002 clk  input  1  clock; all logic rising-edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a bounding-box search of the region; sampled in IDLE only.
REQ-005 rx0, ry0, rx1, ry1  input  10 each  inclusive region corners; sampled with start.
REQ-006 busy  output  1  high from start acceptance until the done pulse, inclusive.
REQ-007 done  output  1  one-cycle pulse at the end of every accepted request.
REQ-008 valid  output  1  box found; level, updated with done, held until next accepted start.
REQ-009 err  output  1  invalid region or timeout; level, same update rule as valid.
REQ-010 box_top, box_bottom, box_left, box_right  output  10 each  result coordinates; held with valid.
REQ-011 eng_start  output  1  one-cycle launch pulse to the edge-search engine.
REQ-012 eng_x0, eng_y0, eng_x1, eng_y1  output  10 each  engine window start/end; registered, stable from eng_start until done/next launch.
REQ-013 eng_dir  output  2  engine direction: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT.
REQ-014 eng_done  input  1  engine finished (level; may remain high from the prior pass).
REQ-015 eng_found  input  1  engine hit a set pixel; valid while eng_done high.
REQ-016 eng_fx, eng_fy  input  10 each  hit coordinate; valid while eng_done and eng_found high.

Function
REQ-017 States: IDLE, LAUNCH, ARM, WAIT, STORE, FINISH.
REQ-018 IDLE: start=1 with rx0<=rx1 and ry0<=ry1 -> latch region, pass:=TOP, busy=1, go LAUNCH.
REQ-019 IDLE: start=1 with rx0>rx1 or ry0>ry1 -> FINISH with err=1, valid=0; no eng_start issued.
REQ-020 LAUNCH: drive window/dir for current pass, eng_start=1 for exactly this cycle, clear timeout counter, go ARM.
REQ-021 ARM: one cycle, eng_done ignored (stale-done guard), go WAIT.
REQ-022 WAIT: counter increments per cycle; eng_done=1 -> STORE; counter reaching TIMEOUT first -> FINISH with err=1, valid=0.
REQ-023 STORE: eng_found=0 on pass TOP -> FINISH, valid=0, err=0 (empty region).
REQ-024 STORE: eng_found=0 on any later pass -> FINISH, err=1 (inconsistent engine).
REQ-025 STORE: eng_found=1 -> record coordinate per pass, advance pass, go LAUNCH; after pass RIGHT go FINISH with valid=1.
REQ-026 Pass TOP: dir 11, start (rx0,ry0), end (rx1,ry1); box_top := eng_fy.
REQ-027 Pass BOTTOM: dir 10, start (rx1,ry1), end (rx0,box_top); box_bottom := eng_fy.
REQ-028 Pass LEFT: dir 01, start (rx0,box_top), end (rx1,box_bottom); box_left := eng_fx.
REQ-029 Pass RIGHT: dir 00, start (rx1,box_bottom), end (rx0,box_top); box_right := eng_fx.
REQ-030 FINISH: done=1 one cycle, busy=0 next cycle, go IDLE; valid/err/box_* update in this cycle.
REQ-031 start while busy is ignored; no queuing.
REQ-032 Coordinates pass through unmodified; no arithmetic on 10-bit values; counter is 19 bits, saturating compare >= TIMEOUT.
REQ-033 Minimum latency: start to done = 4 passes x (LAUNCH+ARM+WAIT(>=1)+STORE) + FINISH = 17 cycles.
REQ-034 Single-pixel region (rx0=rx1, ry0=ry1) is legal; all four passes run.

Reset
REQ-035 reset=1 at any cycle, including mid-pass: state IDLE, busy=0, done=0, valid=0, err=0, eng_start=0, eng_dir=00, all 10-bit outputs 0, counter 0.
REQ-036 Engine result arriving after reset is ignored; first post-reset start behaves as from power-up.

Verification
REQ-037 Region (0,0)-(639,479), engine model with blob 100..120 x 50..60 -> windows per REQ-026..029, box top=50 bottom=60 left=100 right=120, valid=1, err=0, one done pulse.
REQ-038 Engine returns eng_found=0 on TOP -> exactly 1 eng_start, done pulse, valid=0, err=0.
REQ-039 rx0=10, rx1=5 -> done within 2 cycles of start, err=1, eng_start never asserted.
REQ-040 TIMEOUT=50, engine never asserts eng_done -> done 52 cycles after eng_start, err=1, valid=0.
REQ-041 eng_done held high from prior pass plus start pulses during busy -> no premature STORE, starts ignored, 4 eng_start pulses total.
REQ-042 reset asserted during pass LEFT -> all outputs 0 next cycle; subsequent start completes normally.
